// File: rtl/state_machine.sv
`default_nettype none
// ============================================================================
// Module      : state_machine
// Description : Per-block MSI snooping-coherence controller. Computes the
//               next block state combinationally and registers the bus
//               message, write-back and memory-abort pulses.
// Revision    : 1.0  initial release
// ============================================================================
module state_machine (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  state,
    input  logic [21:0] request,
    input  logic        listen,
    output logic [1:0]  newState,
    output logic [21:0] CDB,
    output logic        dataWB,
    output logic        abortMem
);

    localparam logic [1:0] c_ST_I = 2'b00;
    localparam logic [1:0] c_ST_S = 2'b01;
    localparam logic [1:0] c_ST_M = 2'b10;

    localparam logic [3:0] c_T_LOCAL = 4'b1000;
    localparam logic [3:0] c_T_RDMS  = 4'b0100;
    localparam logic [3:0] c_T_WRMS  = 4'b0010;
    localparam logic [3:0] c_T_INV   = 4'b0001;
    localparam logic [3:0] c_T_NONE  = 4'b0000;

    logic [1:0]  w_cur;
    logic [3:0]  w_type;
    logic        w_hit;
    logic        w_rd;
    logic [15:0] w_addr;
    logic [1:0]  w_next;
    logic [3:0]  w_msg;
    logic        w_wb;
    logic        w_abort;
    logic [21:0] w_cdb;

    logic [21:0] r_cdb;
    logic        r_wb;
    logic        r_abort;

    // The illegal encoding 11 is folded onto Invalid before any decision.
    assign w_cur  = (state == 2'b11) ? c_ST_I : state;
    assign w_type = request[21:18];
    assign w_hit  = request[17];
    assign w_rd   = request[16];
    assign w_addr = request[15:0];

    always_comb begin
        w_next  = w_cur;
        w_msg   = c_T_NONE;
        w_wb    = 1'b0;
        w_abort = 1'b0;
        if (listen) begin
            case (w_type)
                c_T_LOCAL: begin
                    case (w_cur)
                        c_ST_S: begin
                            if (w_rd) begin
                                w_next = c_ST_S;
                                w_msg  = w_hit ? c_T_NONE : c_T_RDMS;
                            end else begin
                                w_next = c_ST_M;
                                w_msg  = w_hit ? c_T_INV : c_T_WRMS;
                            end
                        end
                        c_ST_M: begin
                            if (!w_hit) begin
                                w_wb   = 1'b1;
                                w_next = w_rd ? c_ST_S : c_ST_M;
                                w_msg  = w_rd ? c_T_RDMS : c_T_WRMS;
                            end
                        end
                        default: begin
                            w_next = w_rd ? c_ST_S : c_ST_M;
                            w_msg  = w_rd ? c_T_RDMS : c_T_WRMS;
                        end
                    endcase
                end
                c_T_RDMS, c_T_WRMS, c_T_INV: begin
                    if (w_hit && (w_cur != c_ST_I)) begin
                        w_next  = (w_type == c_T_RDMS) ? c_ST_S : c_ST_I;
                        w_wb    = (w_cur == c_ST_M);
                        // An invalidate means the requester already holds the data.
                        w_abort = (w_cur == c_ST_M) && (w_type != c_T_INV);
                    end
                end
                default: begin
                    w_next = w_cur;
                end
            endcase
        end
    end

    assign w_cdb = (w_msg == c_T_NONE) ? 22'd0
                 : {w_msg, 1'b0, (w_msg == c_T_RDMS), w_addr};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cdb   <= 22'd0;
            r_wb    <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_cdb   <= w_cdb;
            r_wb    <= w_wb;
            r_abort <= w_abort;
        end
    end

    assign newState = Reset ? c_ST_I : w_next;
    assign CDB      = r_cdb;
    assign dataWB   = r_wb;
    assign abortMem = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_state_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_machine
// Description : Self-checking bench for state_machine: directed vector table,
//               multi-cycle corner sequences and randomized model comparison.
// Revision    : 1.0  initial release
// ============================================================================
module tb_state_machine;

    logic        Clock;
    logic        Reset;
    logic [1:0]  state;
    logic [21:0] request;
    logic        listen;
    logic [1:0]  newState;
    logic [21:0] CDB;
    logic        dataWB;
    logic        abortMem;

    int n_pass;
    int n_total;

    state_machine dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .state    (state),
        .request  (request),
        .listen   (listen),
        .newState (newState),
        .CDB      (CDB),
        .dataWB   (dataWB),
        .abortMem (abortMem)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  st;
        logic [21:0] req;
        logic        lis;
        logic [1:0]  ns;
        logic [21:0] cdb;
        logic        wb;
        logic        ab;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: reasons about copy ownership rather than a transition table.
    function automatic void model(input logic [1:0] st_in, input logic [21:0] req,
                                  input logic lis, output logic [1:0] ns,
                                  output logic [21:0] cdb, output logic wb,
                                  output logic ab);
        logic [1:0] st;
        logic [3:0] ty;
        logic hit, rd, have, own, miss;
        logic [3:0] msg;
        st = (st_in == 2'd3) ? 2'd0 : st_in;
        ty = req[21:18]; hit = req[17]; rd = req[16];
        have = (st != 2'd0); own = (st == 2'd2);
        ns = st; cdb = '0; wb = 0; ab = 0; msg = 4'd0;
        if (lis && ty == 4'b1000) begin
            miss = !(have && hit);
            ns   = !rd ? 2'd2 : ((own && hit) ? 2'd2 : 2'd1);
            wb   = own && miss;
            if (miss) msg = rd ? 4'b0100 : 4'b0010;
            else if (!rd && !own) msg = 4'b0001;
            if (msg != 0) cdb = {msg, 1'b0, msg == 4'b0100, req[15:0]};
        end else if (lis && (ty == 4'b0100 || ty == 4'b0010 || ty == 4'b0001)
                     && hit && have) begin
            ns = (ty == 4'b0100) ? 2'd1 : 2'd0;
            wb = own;
            ab = own && (ty != 4'b0001);
        end
    endfunction

    task automatic drive(input logic [1:0] st, input logic [21:0] req, input logic lis);
        state = st; request = req; listen = lis;
    endtask

    task automatic check_outs(input string tag, input logic [21:0] cdb,
                              input logic wb, input logic ab);
        check({tag, ".CDB"},      {10'd0, CDB},      {10'd0, cdb});
        check({tag, ".dataWB"},   {31'd0, dataWB},   {31'd0, wb});
        check({tag, ".abortMem"}, {31'd0, abortMem}, {31'd0, ab});
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        Reset = 1'b1;
        drive(2'd0, 22'd0, 1'b0);

        vecs[0]  = '{2'b00, {4'b1000,1'b0,1'b1,16'h0000}, 1'b1, 2'b01, {4'b0100,1'b0,1'b1,16'h0000}, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, {4'b1000,1'b1,1'b0,16'h0004}, 1'b1, 2'b10, {4'b0001,1'b0,1'b0,16'h0004}, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, {4'b1000,1'b0,1'b1,16'h0008}, 1'b1, 2'b01, {4'b0100,1'b0,1'b1,16'h0008}, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, {4'b0010,1'b1,1'b0,16'h0008}, 1'b1, 2'b00, 22'd0, 1'b1, 1'b1};
        vecs[4]  = '{2'b10, {4'b0010,1'b0,1'b0,16'h0008}, 1'b1, 2'b10, 22'd0, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, {4'b1000,1'b1,1'b0,16'h0010}, 1'b0, 2'b00, 22'd0, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, {4'b1000,1'b1,1'b0,16'h0010}, 1'b0, 2'b01, 22'd0, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, {4'b1000,1'b1,1'b0,16'h0010}, 1'b0, 2'b10, 22'd0, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, {4'b1000,1'b1,1'b0,16'h0010}, 1'b0, 2'b00, 22'd0, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, {4'b1000,1'b0,1'b0,16'h0020}, 1'b1, 2'b10, {4'b0010,1'b0,1'b0,16'h0020}, 1'b0, 1'b0};
        vecs[10] = '{2'b10, {4'b0001,1'b1,1'b0,16'h0030}, 1'b1, 2'b00, 22'd0, 1'b1, 1'b0};
        vecs[11] = '{2'b01, {4'b0100,1'b1,1'b1,16'h0040}, 1'b1, 2'b01, 22'd0, 1'b0, 1'b0};

        @(posedge Clock); #1;
        check("reset.newState", {30'd0, newState}, 32'd0);
        @(posedge Clock); #1;
        check_outs("reset", 22'd0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Consecutive table rows also exercise back-to-back events.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].st, vecs[i].req, vecs[i].lis);
            #1;
            check($sformatf("vec%0d.newState", i), {30'd0, newState}, {30'd0, vecs[i].ns});
            @(posedge Clock); #1;
            check_outs($sformatf("vec%0d", i), vecs[i].cdb, vecs[i].wb, vecs[i].ab);
        end

        // Pulse lasts exactly one cycle.
        drive(2'b10, {4'b1000,1'b0,1'b1,16'h0008}, 1'b1);
        @(posedge Clock); #1;
        check_outs("pulse.on", {4'b0100,1'b0,1'b1,16'h0008}, 1'b1, 1'b0);
        drive(2'b01, 22'd0, 1'b1);
        @(posedge Clock); #1;
        check_outs("pulse.off", 22'd0, 1'b0, 1'b0);

        // Reset wins over a simultaneous event.
        Reset = 1'b1;
        drive(2'b10, {4'b1000,1'b0,1'b1,16'h0008}, 1'b1);
        #1;
        check("rstev.newState", {30'd0, newState}, 32'd0);
        @(posedge Clock); #1;
        check_outs("rstev", 22'd0, 1'b0, 1'b0);
        Reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  st, ens;
            logic [21:0] rq, ecdb;
            logic        ls, ewb, eab, rs;
            logic [3:0]  ty;
            case ($urandom_range(0, 5))
                0: ty = 4'b1000; 1: ty = 4'b0100; 2: ty = 4'b0010;
                3: ty = 4'b0001; 4: ty = 4'b0000; default: ty = 4'($urandom);
            endcase
            st = 2'($urandom);
            rq = {ty, 1'($urandom), 1'($urandom), 16'($urandom)};
            ls = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 19) == 0);
            model(st, rq, ls, ens, ecdb, ewb, eab);
            if (rs) begin ens = 2'd0; ecdb = '0; ewb = 0; eab = 0; end
            Reset = rs;
            drive(st, rq, ls);
            #1;
            check($sformatf("rnd%0d.newState", i), {30'd0, newState}, {30'd0, ens});
            @(posedge Clock); #1;
            check_outs($sformatf("rnd%0d", i), ecdb, ewb, eab);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
